dmem_wait_ctrl: RTL and testbench

//  Parametrised data memory for the single-cycle/multicycle CPU datapath; successor to the fixed DMEM.

---
 rtl/dmem_wait_ctrl_pkg.sv | 27 ++
 rtl/dmem_wait_ctrl_if.sv | 26 ++
 rtl/dmem_wait_ctrl_lane_align.sv | 55 +++++
 rtl/dmem_wait_ctrl.sv | 119 +++++++++++
 tb/tb_dmem_wait_ctrl.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_wait_ctrl_pkg.sv
// Shared encodings for the wait-state data memory: access sizes, FSM states,
// counter width and a constant log2 helper.
package dmem_wait_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int CNT_W = 4;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/dmem_wait_ctrl_if.sv
// Request/response bundle between the CPU datapath and the data memory.
interface dmem_wait_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] DMEM_address;
  logic [DATA_W-1:0] DMEM_data_in;
  logic              DMEM_mem_write;
  logic              DMEM_mem_read;
  logic [1:0]        DMEM_size;
  logic              DMEM_unsigned;
  logic [DATA_W-1:0] DMEM_data_out;
  logic              DMEM_busy;
  logic              DMEM_ready;
  logic              DMEM_error;

  modport master (
    output DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read, DMEM_size, DMEM_unsigned,
    input  DMEM_data_out, DMEM_busy, DMEM_ready, DMEM_error
  );

  modport slave (
    input  DMEM_address, DMEM_data_in, DMEM_mem_write, DMEM_mem_read, DMEM_size, DMEM_unsigned,
    output DMEM_data_out, DMEM_busy, DMEM_ready, DMEM_error
  );
endinterface

// File: rtl/dmem_wait_ctrl_lane_align.sv
// Big-endian lane steering: merges sub-word store data into the stored word and
// extracts/extends sub-word load data. Purely combinational.
module dmem_wait_ctrl_lane_align
  import dmem_wait_ctrl_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  input  logic [31:0] mem_word,
  input  logic [31:0] store_data,
  output logic [31:0] merged_word,
  output logic [31:0] load_data
);

  logic [4:0]  shift;
  logic [31:0] mask;
  logic [31:0] lanes;
  logic [31:0] shifted;

  // Offset 0 is the most significant lane, so the shift is (3 - offset) bytes.
  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    shift = '0;
    mask  = '1;
    lanes = store_data;
    case (size)
      SZ_BYTE: begin
        shift = {~offset, 3'b000};
        mask  = 32'h0000_00FF << shift;
        lanes = {4{store_data[7:0]}};
      end
      SZ_HALF: begin
        shift = {~offset[1], 4'b0000};
        mask  = 32'h0000_FFFF << shift;
        lanes = {2{store_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign merged_word = (mem_word & ~mask) | (lanes & mask);
  assign shifted     = mem_word >> shift;

  always_comb begin
    load_data = mem_word;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'b0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'b0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_wait_ctrl.sv
// Byte-addressed big-endian data memory with programmable wait states, a
// one-cycle ready pulse and alignment/range/size error reporting.
module dmem_wait_ctrl
  import dmem_wait_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input logic             clk,
  input logic             reset,
  dmem_wait_ctrl_if.slave bus
);

  localparam int IDX_W = clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_e            state, state_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              uns_q, rd_q, wr_q;
  logic              err_q;
  logic [DATA_W-1:0] data_out_q;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic              idle;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  size_e             cur_size;
  logic              cur_uns, cur_rd, cur_wr;
  logic [IDX_W-1:0]  idx;
  logic              err_c, enter_done;
  logic [DATA_W-1:0] merged_word, load_data;

  // In IDLE the live inputs describe the request (needed when WAIT_CYCLES is 0
  // and DONE is entered on the accept edge); afterwards the captured copy does.
  assign idle      = (state == ST_IDLE);
  assign cur_addr  = idle ? bus.DMEM_address   : addr_q;
  assign cur_wdata = idle ? bus.DMEM_data_in   : wdata_q;
  assign cur_size  = size_e'(idle ? bus.DMEM_size : size_q);
  assign cur_uns   = idle ? bus.DMEM_unsigned  : uns_q;
  assign cur_rd    = idle ? bus.DMEM_mem_read  : rd_q;
  assign cur_wr    = idle ? bus.DMEM_mem_write : wr_q;
  assign idx       = cur_addr[IDX_W+1:2];

  assign err_c = (cur_rd && cur_wr)
              || (cur_size == SZ_RSVD)
              || (cur_size == SZ_HALF && cur_addr[0])
              || (cur_size == SZ_WORD && cur_addr[1:0] != 2'b00)
              || ((cur_addr >> (IDX_W + 2)) != '0);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: if (bus.DMEM_mem_read || bus.DMEM_mem_write) begin
        state_nx = (WAIT_CYCLES == 0) ? ST_DONE : ST_WAIT;
        cnt_nx   = CNT_LOAD;
      end
      ST_WAIT: if (cnt == '0) state_nx = ST_DONE;
               else           cnt_nx   = cnt - 1'b1;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign enter_done = (state_nx == ST_DONE) && (state != ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      err_q      <= 1'b0;
      data_out_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_nx;
      cnt   <= cnt_nx;
      if (idle) begin
        addr_q  <= bus.DMEM_address;
        wdata_q <= bus.DMEM_data_in;
        size_q  <= bus.DMEM_size;
        uns_q   <= bus.DMEM_unsigned;
        rd_q    <= bus.DMEM_mem_read;
        wr_q    <= bus.DMEM_mem_write;
      end
      if (enter_done) begin
        err_q <= err_c;
        if (cur_rd && !err_c) data_out_q <= load_data;
      end
    end
  end

  // NOTE: the storage array has no reset; reset only suppresses a pending commit.
  always_ff @(posedge clk) begin
    if (!reset && enter_done && cur_wr && !err_c) mem[idx] <= merged_word;
  end

  dmem_wait_ctrl_lane_align u_lane_align (
    .size        (cur_size),
    .offset      (cur_addr[1:0]),
    .is_unsigned (cur_uns),
    .mem_word    (mem[idx]),
    .store_data  (cur_wdata),
    .merged_word (merged_word),
    .load_data   (load_data)
  );

  assign bus.DMEM_ready    = (state == ST_DONE);
  assign bus.DMEM_busy     = !idle;
  assign bus.DMEM_error    = (state == ST_DONE) && err_q;
  assign bus.DMEM_data_out = data_out_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Directed bench for dmem_wait_ctrl: a byte-array memory model predicts every
// cycle's busy/ready/error/data_out for two instances (2 and 0 wait states).
module tb_dmem_wait_ctrl;

  localparam int DEPTH = 256;
  localparam int W0    = 2;
  localparam int W1    = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  dmem_wait_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
  dmem_wait_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) dut0 (
    .clk (clk), .reset (reset), .bus (b0.slave));
  dmem_wait_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) dut1 (
    .clk (clk), .reset (reset), .bus (b1.slave));

  int n_vec = 0;
  int n_err = 0;
  bit run = 1'b0;
  int sel = 0;

  logic        exp_busy, exp_ready, exp_err;
  logic [31:0] exp_dout [2];
  logic [7:0]  mem_m [2][4*DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Compare process: every cycle, mid-period, against the model's expectations.
  always @(negedge clk) begin
    if (run) begin
      if (sel == 0) begin
        check("busy0",  32'(b0.DMEM_busy),  32'(exp_busy));
        check("ready0", 32'(b0.DMEM_ready), 32'(exp_ready));
        check("error0", 32'(b0.DMEM_error), 32'(exp_err));
        check("dout0",  b0.DMEM_data_out,   exp_dout[0]);
      end else begin
        check("busy1",  32'(b1.DMEM_busy),  32'(exp_busy));
        check("ready1", 32'(b1.DMEM_ready), 32'(exp_ready));
        check("error1", 32'(b1.DMEM_error), 32'(exp_err));
        check("dout1",  b1.DMEM_data_out,   exp_dout[1]);
      end
    end
  end

  task automatic drive(input int d, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size, input bit uns);
    if (d == 0) begin
      b0.DMEM_mem_read = rd; b0.DMEM_mem_write = wr; b0.DMEM_address = addr;
      b0.DMEM_data_in = data; b0.DMEM_size = size; b0.DMEM_unsigned = uns;
    end else begin
      b1.DMEM_mem_read = rd; b1.DMEM_mem_write = wr; b1.DMEM_address = addr;
      b1.DMEM_data_in = data; b1.DMEM_size = size; b1.DMEM_unsigned = uns;
    end
  endtask

  function automatic void model_eval(input int d, input bit rd, input bit wr, input int addr,
                                     input logic [1:0] size, input bit uns,
                                     output bit err, output logic [31:0] ld);
    int n;
    n   = 1 << size;
    err = (rd && wr) || (size == 2'b11) || (size == 2'b01 && addr % 2 != 0)
       || (size == 2'b10 && addr % 4 != 0) || (addr >= 4 * DEPTH);
    ld  = '0;
    if (!err && rd) begin
      for (int i = 0; i < n; i++) ld = (ld << 8) | 32'(mem_m[d][addr+i]);
      if (!uns && n < 4 && ld[8*n-1]) ld = ld | (32'hFFFF_FFFF << (8 * n));
    end
  endfunction

  function automatic void model_store(input int d, input int addr, input logic [31:0] data,
                                      input logic [1:0] size);
    int n;
    n = 1 << size;
    for (int i = 0; i < n; i++) mem_m[d][addr+i] = data[8*(n-1-i) +: 8];
  endfunction

  function automatic void exp_idle();
    exp_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0;
  endfunction

  // One transaction on instance d; abort_k >= 0 asserts reset in that wait cycle.
  task automatic run_op(input int d, input bit rd, input bit wr, input int addr,
                        input logic [31:0] data, input logic [1:0] size, input bit uns,
                        input bit pulse, input int abort_k);
    int w;
    bit err;
    logic [31:0] ld;
    w = (d == 0) ? W0 : W1;
    sel = d;
    @(negedge clk);
    drive(d, rd, wr, addr, data, size, uns);
    model_eval(d, rd, wr, addr, size, uns, err, ld);
    @(posedge clk); #1;
    drive(d, 0, 0, 0, 0, 2'b00, 0);
    for (int k = 0; k <= w; k++) begin
      exp_busy  = 1'b1;
      exp_ready = (k == w);
      exp_err   = (k == w) && err;
      if (k == abort_k) begin
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_idle();
        exp_dout[0] = '0;
        exp_dout[1] = '0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if (k == w) begin
        if (wr && !err) model_store(d, addr, data, size);
        if (rd && !err) exp_dout[d] = ld;
      end
      if (pulse && k == 0 && w > 0) begin
        @(negedge clk);
        drive(d, 1, 0, addr ^ 8, 32'h0, 2'b10, 0);
      end
      @(posedge clk); #1;
      if (pulse && k == 0) drive(d, 0, 0, 0, 0, 2'b00, 0);
    end
    exp_idle();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 2'b00, 0);
    drive(1, 0, 0, 0, 0, 2'b00, 0);
    @(posedge clk); #1;
    exp_idle();
    exp_dout[0] = '0;
    exp_dout[1] = '0;
    run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Word store/load round trip.
    run_op(0, 0, 1, 20, 32'h0000_0048, 2'b10, 0, 0, -1);
    run_op(0, 1, 0, 20, 32'h0,         2'b10, 0, 0, -1);
    check("lw20", b0.DMEM_data_out, 32'h0000_0048);

    // Byte lanes, big-endian.
    run_op(0, 0, 1, 40, 32'h1122_3344, 2'b10, 0, 0, -1);
    run_op(0, 0, 1, 41, 32'h0000_00AB, 2'b00, 0, 0, -1);
    run_op(0, 1, 0, 41, 32'h0,         2'b00, 1, 0, -1);
    check("lbu41", b0.DMEM_data_out, 32'h0000_00AB);
    run_op(0, 1, 0, 40, 32'h0,         2'b10, 0, 0, -1);
    check("lw40a", b0.DMEM_data_out, 32'h11AB_3344);
    run_op(0, 1, 0, 41, 32'h0,         2'b00, 0, 0, -1);
    check("lb41", b0.DMEM_data_out, 32'hFFFF_FFAB);

    // Half lanes and extension.
    run_op(0, 0, 1, 42, 32'h0000_8078, 2'b01, 0, 0, -1);
    run_op(0, 1, 0, 42, 32'h0,         2'b01, 0, 0, -1);
    check("lh42", b0.DMEM_data_out, 32'hFFFF_8078);
    run_op(0, 1, 0, 42, 32'h0,         2'b01, 1, 0, -1);
    check("lhu42", b0.DMEM_data_out, 32'h0000_8078);
    run_op(0, 1, 0, 40, 32'h0,         2'b10, 0, 0, -1);
    check("lw40b", b0.DMEM_data_out, 32'h11AB_8078);

    // Misaligned, out of range, reserved size: no write, data_out held.
    run_op(0, 1, 0, 22,   32'h0,         2'b10, 0, 0, -1);
    run_op(0, 1, 0, 21,   32'h0,         2'b01, 0, 0, -1);
    check("err_hold", b0.DMEM_data_out, 32'h11AB_8078);
    run_op(0, 0, 1, 22,   32'h0000_DEAD, 2'b10, 0, 0, -1);
    run_op(0, 1, 0, 1024, 32'h0,         2'b10, 0, 0, -1);
    run_op(0, 1, 0, 20,   32'h0,         2'b11, 0, 0, -1);
    run_op(0, 1, 0, 20,   32'h0,         2'b10, 0, 0, -1);
    check("lw20b", b0.DMEM_data_out, 32'h0000_0048);

    // Read and write together is an error; requests during WAIT are ignored.
    run_op(0, 1, 1, 20, 32'hFFFF_FFFF, 2'b10, 0, 0, -1);
    run_op(0, 1, 0, 20, 32'h0,         2'b10, 0, 1, -1);
    check("lw20c", b0.DMEM_data_out, 32'h0000_0048);

    // Reset in the last wait cycle aborts the store.
    run_op(0, 0, 1, 40, 32'h0000_0078, 2'b10, 0, 0, 1);
    check("abort_dout", b0.DMEM_data_out, 32'h0);
    run_op(0, 1, 0, 40, 32'h0,         2'b10, 0, 0, -1);
    check("lw40c", b0.DMEM_data_out, 32'h11AB_8078);

    // Zero-wait instance: ready the cycle after accept.
    run_op(1, 0, 1, 8,  32'h1234_5678, 2'b10, 0, 0, -1);
    run_op(1, 1, 0, 8,  32'h0,         2'b10, 0, 0, -1);
    check("w0_lw8", b1.DMEM_data_out, 32'h1234_5678);
    run_op(1, 1, 0, 11, 32'h0,         2'b00, 0, 0, -1);
    check("w0_lb11", b1.DMEM_data_out, 32'h0000_0078);
    run_op(1, 1, 0, 8,  32'h0,         2'b01, 0, 0, -1);
    check("w0_lh8", b1.DMEM_data_out, 32'h0000_1234);
    run_op(1, 1, 0, 2,  32'h0,         2'b10, 0, 0, -1);
    check("w0_err_hold", b1.DMEM_data_out, 32'h0000_1234);

    @(posedge clk);
    @(posedge clk);
    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
